// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/compare ops plus an iterative
// shift-add multiplier, fronted by a start/busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [2:0]      OP_MUL   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_mcand, w_mcand_next;
  logic [WIDTH-1:0] r_mplier, w_mplier_next;
  logic [WIDTH-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_result, w_result_next;
  logic             r_zero, w_zero_next;

  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_lt;

  assign w_lt       = $signed(SrcA) < $signed(SrcB);
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_single = '0;
    case (ALUControl)
      3'b000:  w_single = SrcA & SrcB;
      3'b001:  w_single = SrcA | SrcB;
      3'b010:  w_single = SrcA + SrcB;
      3'b011:  w_single = SrcA ^ SrcB;
      3'b100:  w_single = SrcA - SrcB;
      3'b110:  w_single = WIDTH'(w_lt);
      3'b111:  w_single = ~(SrcA | SrcB);
      default: w_single = '0;  // MUL goes through the iterative path
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_acc_next    = r_acc;
    w_cnt_next    = r_cnt;
    w_result_next = r_result;
    w_zero_next   = r_zero;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (ALUControl == OP_MUL) begin
            w_mcand_next  = SrcA;
            w_mplier_next = SrcB;
            w_acc_next    = '0;
            w_cnt_next    = '0;
            w_state_next  = S_MUL;
          end else begin
            w_result_next = w_single;
            w_zero_next   = (w_single == '0);
            w_state_next  = S_DONE;
          end
        end
      end
      S_MUL: begin
        w_acc_next    = w_acc_step;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt + CNT_W'(1);
        // Final step publishes the accumulator including this step's add.
        if (r_cnt == LAST_CNT) begin
          w_result_next = w_acc_step;
          w_zero_next   = (w_acc_step == '0);
          w_state_next  = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
      r_result <= w_result_next;
      r_zero   <= w_zero_next;
    end
  end

  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued at issue
// time and compared against ALUResult/Zero when done pulses.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ctl;
  logic [W-1:0] a, b;
  logic [W-1:0] res;
  logic         zero, busy, done;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUControl(ctl), .SrcA(a), .SrcB(b),
    .ALUResult(res), .Zero(zero), .busy(busy), .done(done)
  );

  function automatic logic [W-1:0] model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    case (c)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b011:  return x ^ y;
      3'b100:  return x - y;
      3'b101:  return x * y;
      3'b110:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Drive start for one cycle (sampled at the next rising edge), then scramble inputs.
  task automatic issue(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input bit track);
    start = 1'b1; ctl = c; a = x; b = y;
    if (track) exp_q.push_back(model(c, x, y));
    step();
    start = 1'b0; ctl = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctl = '0; a = '0; b = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({res, zero, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: res=%h zero=%b busy=%b done=%b expected res=0 zero=1 busy=0 done=0", res, zero, busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      ctl = 3'($urandom); a = $urandom; b = $urandom;
      checks++;
      if ({res, zero, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle[%0d]: res=%h zero=%b busy=%b done=%b expected res=0 zero=1 busy=0 done=0", i, res, zero, busy, done);
      end
    end
    last_res = '0;
    $display("test_reset: reset and 10 idle cycles checked");
  endtask

  // Table-driven single-cycle ops: done the cycle after start, then idle.
  task automatic test_single(input string name, input logic [2:0] codes[], input logic [W-1:0] as[], input logic [W-1:0] bs[]);
    logic [W-1:0] e;
    for (int i = 0; i < codes.size(); i++) begin
      issue(codes[i], as[i], bs[i], 1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d] latency: done=%b busy=%b expected done=1 busy=1", name, i, done, busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (res !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL %s[%0d] result: got %h zero=%b expected %h zero=%b", name, i, res, zero, e, (e == '0));
      end
      last_res = e;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] after_done: done=%b busy=%b expected 0 0", name, i, done, busy);
      end
      $display("%s[%0d]: code=%b A=%h B=%h -> %h", name, i, codes[i], as[i], bs[i], res);
    end
  endtask

  task automatic test_add_sub();
    test_single("add_sub", '{3'b010, 3'b100}, '{32'd5, 32'd3}, '{32'd7, 32'd3});
  endtask

  task automatic test_slt_logic();
    test_single("slt_logic",
      '{3'b110, 3'b110, 3'b111, 3'b000, 3'b001, 3'b011},
      '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hF0F0_1234, 32'hF000_000F, 32'hAAAA_5555},
      '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0FF0_FF00, 32'h0000_FF00, 32'hFFFF_0000});
  endtask

  task automatic test_mul();
    logic [W-1:0] as[2] = '{32'hFFFF_FFFF, 32'd1234};
    logic [W-1:0] bs[2] = '{32'd3, 32'd5678};
    logic [W-1:0] prev, e;
    for (int i = 0; i < 2; i++) begin
      prev = last_res;
      issue(3'b101, as[i], bs[i], 1'b1);
      for (int k = 1; k <= 32; k++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || res !== prev) begin
          errors++;
          $display("FAIL mul[%0d] cycle N+%0d: busy=%b done=%b res=%h expected busy=1 done=0 res=%h", i, k, busy, done, res, prev);
        end
        step();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL mul[%0d] done_at_N+33: done=%b busy=%b expected 1 1", i, done, busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (res !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL mul[%0d] result: got %h zero=%b expected %h zero=%b", i, res, zero, e, (e == '0));
      end
      last_res = e;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul[%0d] after_done: done=%b busy=%b expected 0 0", i, done, busy);
      end
      $display("mul[%0d]: A=%h B=%h -> %h", i, as[i], bs[i], res);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] prev, e;
    prev = last_res;
    issue(3'b101, 32'd6, 32'd7, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || res !== prev) begin
        errors++;
        $display("FAIL busy_start cycle N+%0d: busy=%b done=%b res=%h expected busy=1 done=0 res=%h", k, busy, done, res, prev);
      end
      if (k == 5) begin
        start = 1'b1; ctl = 3'b010; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_start done_at_N+33: done=%b expected 1", done);
    end
    e = exp_q.pop_front();
    checks++;
    if (res !== e || zero !== (e == '0)) begin
      errors++;
      $display("FAIL busy_start result: got %h expected %h", res, e);
    end
    last_res = e;
    start = 1'b1; ctl = 3'b010; a = 32'd1; b = 32'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || res !== e) begin
        errors++;
        $display("FAIL busy_start idle[%0d]: done=%b busy=%b res=%h expected 0 0 %h", k, done, busy, res, e);
      end
      step();
    end
    $display("start_while_busy: 6*7 -> %h, extra starts ignored", res);
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] e;
    issue(3'b101, 32'd9, 32'd9, 1'b0);
    for (int k = 1; k < 10; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rst_mul cycle N+%0d: done=%b busy=%b expected 0 1", k, done, busy);
      end
      step();
    end
    rst = 1'b1; start = 1'b1; ctl = 3'b010;
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({res, zero, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mul state: res=%h zero=%b busy=%b done=%b expected 0 1 0 0", res, zero, busy, done);
    end
    for (int k = 0; k < 35; k++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || res !== '0) begin
        errors++;
        $display("FAIL rst_mul aborted[%0d]: done=%b busy=%b res=%h expected 0 0 0", k, done, busy, res);
      end
    end
    issue(3'b010, 32'd2, 32'd2, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || res !== e || zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mul add: done=%b res=%h zero=%b expected 1 %h 0", done, res, zero, e);
    end
    last_res = e;
    step();
    $display("reset_mid_mul: aborted, then 2+2 -> %h", e);
  endtask

  // One non-MUL op every 2 cycles: new start in the cycle right after done.
  task automatic test_back_to_back();
    logic [2:0]   c;
    logic [W-1:0] x, y, e;
    for (int i = 0; i < 8; i++) begin
      c = 3'($urandom);
      if (c == 3'b101) c = 3'b100;
      x = $urandom; y = (i == 3) ? x : $urandom;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d] ready: busy=%b expected 0", i, busy);
      end
      issue(c, x, y, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || res !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL b2b[%0d]: done=%b res=%h zero=%b expected 1 %h %b", i, done, res, zero, e, (e == '0));
      end
      $display("b2b[%0d]: code=%b A=%h B=%h -> %h", i, c, x, y, res);
      last_res = e;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt_logic();
    test_mul();
    test_start_while_busy();
    test_reset_mid_mul();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execution unit that consumes the 3-bit ALUControl code produced by the ALU decoder and operates on two WIDTH-bit operands.
- Single-cycle ops (logic, add, sub, slt) complete in one cycle.
- MUL (ALUControl=101, funct 011100) runs as an iterative shift-add multiplier over WIDTH cycles.
- Sits between the decoder/register-file read and the writeback mux, with a start/busy/done handshake so the datapath can stall during MUL.

Parameters:
WIDTH, 32, operand/result width in bits; MUL iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when busy=0
ALUControl  input  3  operation code, sampled when start accepted
SrcA  input  WIDTH  operand A, sampled when start accepted
SrcB  input  WIDTH  operand B, sampled when start accepted
ALUResult  output  WIDTH  registered result; holds last value until next done
Zero  output  1  registered; 1 when ALUResult==0, updates with ALUResult
busy  output  1  1 whenever state != IDLE
done  output  1  one-cycle pulse; ALUResult/Zero are valid from this cycle onward

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state: state=IDLE, ALUResult=0, Zero=1, done=0, busy=0. Internal operand, accumulator and counter registers cleared.
- Reset mid-MUL aborts the operation: no done pulse, ALUResult returns to 0. rst has priority over start in the same cycle.
- ALUControl encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 SUB (A-B)
  - 101 MUL
  - 110 SLT (signed: result 1 if $signed(A)<$signed(B), else 0, zero-extended)
  - 111 NOR
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- MUL returns the low WIDTH bits of the product; identical for signed and unsigned operands.
- States:
  - IDLE:
    - start=0: remain in IDLE.
    - start=1 with code != 101: compute result, register ALUResult/Zero, go to DONE.
    - start=1 with code 101: latch multiplicand=SrcA, multiplier=SrcB, acc=0, cnt=0, go to MUL.
  - MUL, one step per cycle:
    - If multiplier[0]=1, acc = acc + multiplicand (mod 2^WIDTH).
    - multiplicand <<= 1; multiplier >>= 1; cnt++.
    - When cnt==WIDTH-1 (last step), register ALUResult = final acc (including that step), register Zero, and go to DONE.
  - DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- Latency, with start accepted at edge N:
  - Non-MUL: done high in cycle N+1.
  - MUL: done high in cycle N+WIDTH+1 (N+33 for WIDTH=32).
- busy is high in MUL and DONE.
- start while busy=1 (including during DONE) is ignored and not queued. Operand and code changes while busy have no effect.
- A new start is accepted the cycle after done (back-to-back throughput: one non-MUL op every 2 cycles).
- ALUResult and Zero change only on the done transition or on reset. They are stable otherwise, including during MUL.
- Undefined ALUControl is impossible (all 8 codes defined). No X-propagation from unused paths.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ALUResult=0, Zero=1, busy=0, done=0. Outputs unchanged for 10 idle cycles with start=0.
- ADD/SUB/Zero: start with code 010, A=5, B=7 -> done at N+1, ALUResult=12, Zero=0. Next op code 100, A=3, B=3 -> ALUResult=0, Zero=1.
- SLT signed and logic ops:
  - code 110, A=0xFFFFFFFF, B=1 -> ALUResult=1.
  - code 110, A=1, B=0xFFFFFFFF -> 0.
  - code 111, A=0, B=0 -> 0xFFFFFFFF.
- MUL latency/wrap: code 101, A=0xFFFFFFFF, B=3 -> busy high N+1..N+33, done only at N+33, ALUResult=0xFFFFFFFD. ALUResult holds the previous value until N+33. Also A=1234, B=5678 -> 7006652.
- Start while busy: during MUL (A=6, B=7) pulse start with code 010, A=1, B=1 at N+5 and again in the DONE cycle -> ignored, single done at N+33 with ALUResult=42, then IDLE.
- Reset mid-MUL: start MUL A=9, B=9, assert rst at N+10 -> no done pulse, ALUResult=0, Zero=1, busy=0. A following ADD 2+2 -> ALUResult=4 one cycle after its start.
